// File: rtl/modsq_pkg.sv
// Shared parameters and types for the modular-squarer result path.
// Sizes follow the 1024-bit modulus with 16-bit digit weights.
package modsq_pkg;

  localparam int MOD_LEN            = 1024;
  localparam int WORD_LEN           = 16;
  localparam int COEF_BITS          = 17;
  localparam int LANE_BITS          = 32;
  localparam int REDUNDANT_ELEMENTS = 1;
  localparam int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;
  localparam int RESULT_BITS        = NUM_ELEMENTS * WORD_LEN;
  localparam int CARRY_BITS         = COEF_BITS - WORD_LEN + 1;
  localparam int IDX_BITS           = $clog2(NUM_ELEMENTS);

  typedef logic [COEF_BITS-1:0]  coef_t;
  typedef logic [CARRY_BITS-1:0] carry_t;
  typedef logic [IDX_BITS-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } norm_state_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_ELEMENTS - 1);

endpackage

// File: rtl/modsq_result_normalizer.sv
// Serial carry-propagation of the redundant squarer output
// into a plain binary integer, one digit per cycle.
module modsq_result_normalizer
  import modsq_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_ELEMENTS*LANE_BITS-1:0] sq_coefs,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [RESULT_BITS-1:0]            result,
  output logic                              overflow
);

  norm_state_t state, state_nxt;

  coef_t [NUM_ELEMENTS-1:0] lanes;
  coef_t [NUM_ELEMENTS-1:0] lanes_in;

  carry_t           carry;
  idx_t             idx;
  logic [COEF_BITS:0] sum;
  logic             last;
  logic             unused_lane_bits;

  always_comb begin
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      lanes_in[j] = sq_coefs[j*LANE_BITS +: COEF_BITS];
    end
  end

  // upper bits of each lane carry no information
  assign unused_lane_bits = ^sq_coefs;

  assign sum  = {1'b0, lanes[0]}
              + {{(COEF_BITS+1-CARRY_BITS){1'b0}}, carry};
  assign last = (idx == LAST_IDX);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lanes    <= '0;
      carry    <= '0;
      idx      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lanes    <= lanes_in;
            carry    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
          end
        end
        BUSY: begin
          lanes  <= lanes >> COEF_BITS;
          carry  <= sum[COEF_BITS:WORD_LEN];
          idx    <= idx + 1'b1;
          result <= {sum[WORD_LEN-1:0],
                     result[RESULT_BITS-1:WORD_LEN]};
          if (last) overflow <= (sum[COEF_BITS:WORD_LEN] != '0);
        end
        default: ;
      endcase
    end
  end

endmodule
